// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: reset/stop levels,
// the stall bus type, the per-stage stall patterns and the EX timer states.
package pipe_stall_ctrl_pkg;

    localparam logic        RstEnable = 1'b1;
    localparam logic        Stop      = 1'b1;
    localparam logic        NoStop    = 1'b0;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    // Stall bus spans bits 5:0 (pc, IF, ID, EX, MEM, WB)
    localparam int unsigned StallBusMsb = 5;
    typedef logic [StallBusMsb:0] stall_bus_t;

    // Each pattern holds every stage up to the requester and bubbles the next one
    localparam stall_bus_t StallNone = 6'b000000;
    localparam stall_bus_t StallIf   = 6'b000011;
    localparam stall_bus_t StallId   = 6'b000111;
    localparam stall_bus_t StallEx   = 6'b001111;
    localparam stall_bus_t StallMem  = 6'b011111;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } mc_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_mc_timer.sv
// Multi-cycle EX operation timer: IDLE/BUSY FSM with a down-counter and a
// registered done pulse. Produces the EX-level stall contribution.
module pipe_stall_ctrl_mc_timer
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             ex_stall,
    output logic             busy,
    output logic             done
);

    mc_state_e        state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // State register with synchronous reset; reset drops any pending done
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state: the start cycle is the first stalled cycle, so BUSY counts len-2 down to 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (len >= LEN_W'(2)) begin
                        state_d = StBusy;
                        cnt_d   = len - LEN_W'(2);
                    end else begin
                        // len 0 or 1 finishes without entering BUSY
                        done_d = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LEN_W'(1);
                end else begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs: stall in the start cycle (nonzero length) and for the whole of BUSY
    always_comb begin
        busy     = (state_q == StBusy);
        ex_stall = busy | ((state_q == StIdle) & start & (len != '0));
        done     = done_q;
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: prioritises stage stall requests into the shared
// stall vector, times multi-cycle EX operations, counts stalled cycles and
// watches for stalls that never release.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT = 1024,
    parameter int unsigned LEN_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_from_if,
    input  logic             stallreq_from_id,
    input  logic             stallreq_from_ex,
    input  logic             stallreq_from_mem,
    input  logic             ex_mc_start,
    input  logic [LEN_W-1:0] ex_mc_len,
    input  logic             perf_clr,
    output stall_bus_t       stall,
    output logic             ex_mc_done,
    output logic             ex_mc_busy,
    output logic [31:0]      stall_cycles,
    output logic             stall_timeout
);

    localparam logic [15:0] WdogLim = 16'(WDOG_LIMIT);

    logic        mc_stall;
    logic        ex_level_req;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] wdog_q, wdog_d;
    logic        timeout_q, timeout_d;

    pipe_stall_ctrl_mc_timer #(
        .LEN_W (LEN_W)
    ) u_mc_timer (
        .clk      (clk),
        .rst      (rst),
        .start    (ex_mc_start),
        .len      (ex_mc_len),
        .ex_stall (mc_stall),
        .busy     (ex_mc_busy),
        .done     (ex_mc_done)
    );

    // Highest requesting stage wins; reset forces the vector clear
    always_comb begin
        ex_level_req = stallreq_from_ex | mc_stall;
        if (stallreq_from_mem) begin
            stall = StallMem;
        end else if (ex_level_req) begin
            stall = StallEx;
        end else if (stallreq_from_id) begin
            stall = StallId;
        end else if (stallreq_from_if) begin
            stall = StallIf;
        end else begin
            stall = StallNone;
        end
        if (rst == RstEnable) begin
            stall = StallNone;
        end
    end

    // Counter next-state: saturating perf count, watchdog holding at its limit
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (perf_clr) begin
            stall_cycles_d = ZeroWord;
        end else if ((stall[0] == Stop) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end

        wdog_d = wdog_q;
        if (stall[0] == NoStop) begin
            wdog_d = '0;
        end else if (wdog_q != WdogLim) begin
            wdog_d = wdog_q + 16'd1;
        end

        timeout_d = timeout_q | (wdog_d == WdogLim);
    end

    // Counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            stall_cycles_q <= ZeroWord;
            wdog_q         <= '0;
            timeout_q      <= 1'b0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            wdog_q         <= wdog_d;
            timeout_q      <= timeout_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus random
// stimulus, all compared against a cycle-indexed behavioural model.
module tb_pipe_stall_ctrl;

    localparam int unsigned WdogLimit = 8;
    localparam int unsigned LenW      = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            stallreq_from_if;
    logic            stallreq_from_id;
    logic            stallreq_from_ex;
    logic            stallreq_from_mem;
    logic            ex_mc_start;
    logic [LenW-1:0] ex_mc_len;
    logic            perf_clr;
    logic [5:0]      stall;
    logic            ex_mc_done;
    logic            ex_mc_busy;
    logic [31:0]     stall_cycles;
    logic            stall_timeout;

    int checks = 0;
    int errors = 0;

    // Model: an accepted start at cycle t with length N keeps the timer busy
    // over (t, t+N) and signals done at t+max(N,1).
    int     cyc = 0;
    int     op_start = 0;
    int     op_end = 0;
    int     done_at = -1;
    longint m_perf = 0;
    int     m_run = 0;
    bit     m_timeout = 1'b0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .WDOG_LIMIT (WdogLimit),
        .LEN_W      (LenW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_if  (stallreq_from_if),
        .stallreq_from_id  (stallreq_from_id),
        .stallreq_from_ex  (stallreq_from_ex),
        .stallreq_from_mem (stallreq_from_mem),
        .ex_mc_start       (ex_mc_start),
        .ex_mc_len         (ex_mc_len),
        .perf_clr          (perf_clr),
        .stall             (stall),
        .ex_mc_done        (ex_mc_done),
        .ex_mc_busy        (ex_mc_busy),
        .stall_cycles      (stall_cycles),
        .stall_timeout     (stall_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [5:0] exp_pattern(input bit mem, input bit exl, input bit id,
                                               input bit ifr);
        if (mem) return 6'b011111;
        if (exl) return 6'b001111;
        if (id)  return 6'b000111;
        if (ifr) return 6'b000011;
        return 6'b000000;
    endfunction

    function automatic void model_reset();
        op_start  = 0;
        op_end    = 0;
        done_at   = -1;
        m_perf    = 0;
        m_run     = 0;
        m_timeout = 1'b0;
    endfunction

    // One clock cycle: drive at the falling edge, check before the rising edge
    task automatic step(input bit r, input bit fi, input bit fd, input bit fe, input bit fm,
                        input bit st, input int ln, input bit clr);
        bit         busy_m;
        bit         exl;
        logic [5:0] exp_st;
        @(negedge clk);
        rst               = r;
        stallreq_from_if  = fi;
        stallreq_from_id  = fd;
        stallreq_from_ex  = fe;
        stallreq_from_mem = fm;
        ex_mc_start       = st;
        ex_mc_len         = LenW'(ln);
        perf_clr          = clr;
        #1;
        busy_m = (cyc > op_start) && (cyc < op_end);
        exl    = fe || busy_m || (st && !busy_m && ln != 0);
        exp_st = r ? 6'b000000 : exp_pattern(fm, exl, fd, fi);
        check("stall", 32'(stall), 32'(exp_st));
        check("busy", 32'(ex_mc_busy), 32'(busy_m));
        check("done", 32'(ex_mc_done), 32'(cyc == done_at));
        check("stall_cycles", stall_cycles, 32'(m_perf));
        check("timeout", 32'(stall_timeout), 32'(m_timeout));
        if (r) begin
            model_reset();
        end else begin
            if (st && !busy_m) begin
                op_start = cyc;
                op_end   = cyc + ln;
                done_at  = cyc + ((ln == 0) ? 1 : ln);
            end
            if (clr) m_perf = 0;
            else if (exp_st[0] && m_perf < 64'hFFFF_FFFF) m_perf++;
            m_run = exp_st[0] ? m_run + 1 : 0;
            if (m_run >= int'(WdogLimit)) m_timeout = 1'b1;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        stallreq_from_if = 0; stallreq_from_id = 0; stallreq_from_ex = 0;
        stallreq_from_mem = 0; ex_mc_start = 0; ex_mc_len = '0; perf_clr = 0;
        @(posedge clk);

        // Reset: stall cleared even with every request high
        step(1, 1, 1, 1, 1, 1, 5, 0);
        check("rst_stall", 32'(stall), 32'h0);
        idle(2);

        // Priority
        step(0, 0, 1, 0, 1, 0, 0, 0);
        check("prio_id_mem", 32'(stall), 32'h1F);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        check("prio_id", 32'(stall), 32'h07);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check("prio_if", 32'(stall), 32'h03);
        step(0, 1, 1, 1, 0, 0, 0, 0);
        check("prio_ex", 32'(stall), 32'h0F);
        idle(2);

        // Timed operation N=5 with an ignored second start
        step(0, 0, 0, 0, 0, 1, 5, 0);
        check("mc5_t0", 32'(stall), 32'h0F);
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) step(0, 0, 0, 0, 0, 1, 3, 0);
            else        step(0, 0, 0, 0, 0, 0, 0, 0);
            check("mc5_stall", 32'(stall), 32'h0F);
            check("mc5_busy", 32'(ex_mc_busy), 32'h1);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("mc5_done", 32'(ex_mc_done), 32'h1);
        check("mc5_end_stall", 32'(stall), 32'h0);
        idle(3);

        // Edge lengths
        step(0, 0, 0, 0, 0, 1, 1, 0);
        check("len1_stall", 32'(stall), 32'h0F);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("len1_done", 32'(ex_mc_done), 32'h1);
        check("len1_nostall", 32'(stall), 32'h0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        check("len0_stall", 32'(stall), 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("len0_done", 32'(ex_mc_done), 32'h1);
        idle(2);

        // MEM overrides BUSY while the timer keeps running
        step(0, 0, 0, 0, 0, 1, 4, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        check("mem_over_busy", 32'(stall), 32'h1F);
        idle(4);

        // Counters
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("perf7", stall_cycles, 32'd7);
        step(0, 1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("perf_clr", stall_cycles, 32'd0);

        // Watchdog: gapped 7-cycle stalls never trip it
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("wdog_gap", 32'(stall_timeout), 32'h0);
        // 8 consecutive cycles trip it and it sticks
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(3);
        check("wdog_sticky", 32'(stall_timeout), 32'h1);

        // Reset in the middle of a len=10 operation
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 10, 0);
        idle(2);
        step(1, 1, 1, 1, 1, 0, 0, 0);
        check("rst_mid_stall", 32'(stall), 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_mid_busy", 32'(ex_mc_busy), 32'h0);
        check("rst_mid_done", 32'(ex_mc_done), 32'h0);
        idle(10);
        step(0, 0, 0, 0, 0, 1, 3, 0);
        idle(4);

        // Saturation: preload the counter near the top and keep stalling
        @(negedge clk);
        rst = 0; stallreq_from_if = 1; stallreq_from_id = 0; stallreq_from_ex = 0;
        stallreq_from_mem = 0; ex_mc_start = 0; perf_clr = 0;
        force dut.stall_cycles_q = 32'hFFFF_FFFC;
        @(negedge clk);
        release dut.stall_cycles_q;
        repeat (4) @(negedge clk);
        #1 check("perf_sat", stall_cycles, 32'hFFFF_FFFF);
        @(negedge clk);
        #1 check("perf_sat_hold", stall_cycles, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1; stallreq_from_if = 0;
        @(negedge clk);
        model_reset();

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 8,  $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 12, int'($urandom_range(0, 12)),
                 $urandom_range(0, 99) < 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline stall controller for the five-stage core. It collects stall requests from the IF, ID, EX and MEM stages and sequences multi-cycle EX operations with an internal down-counter. It drives the shared 6-bit `stall` vector into the pc and every inter-stage pipeline register (if_id, id_ex, ex_mem, mem_wb). It also keeps a saturating stall-cycle performance counter and a watchdog for stalls that never release.

## Interface
- `WDOG_LIMIT`, default 1024: number of consecutive stalled cycles at which `stall_timeout` sets. Range 2..65535.
- `LEN_W`, default 6: width of the multi-cycle length field.
- `clk` in 1: clock. Everything is sampled on the rising edge.
- `rst` in 1: reset. **One clock; reset is synchronous and active-high.** Compared against `RstEnable`.
- `stallreq_from_if` in 1: instruction fetch not ready.
- `stallreq_from_id` in 1: load-use hazard detected in ID.
- `stallreq_from_ex` in 1: EX requests a stall for the current cycle.
- `stallreq_from_mem` in 1: memory access not ready.
- `ex_mc_start` in 1: single-cycle pulse that starts a controller-timed EX operation.
- `ex_mc_len` in `LEN_W`: length of that operation in cycles. Sampled only together with `ex_mc_start`.
- `perf_clr` in 1: clears `stall_cycles`.
- `stall` out 6: stage hold vector. Bit 0 = pc, bit 1 = IF, bit 2 = ID, bit 3 = EX, bit 4 = MEM, bit 5 = WB. `Stop` = 1.
- `ex_mc_done` out 1: one-cycle pulse marking the end of a timed EX operation.
- `ex_mc_busy` out 1: high while the FSM is in BUSY.
- `stall_cycles` out 32: count of cycles with `stall[0]` == `Stop`.
- `stall_timeout` out 1: sticky watchdog flag.

## Operation
- **Stall encoding:** the highest requesting stage wins.
  - MEM request → `011111`
  - EX-level request → `001111`
  - ID request → `000111`
  - IF request → `000011`
  - no request → `000000`
- Bit 5 is never set.
- **Bubble insertion:** an ID request sets stall[2] = 1 and stall[3] = 0, so id_ex loads a NOP bubble. The EX and MEM patterns work the same way at their own boundaries.
- **EX-level request** is the OR of three terms:
  - `stallreq_from_ex`
  - `ex_mc_start` with a nonzero length, in IDLE
  - the FSM being in BUSY
- **FSM states:** IDLE and BUSY.
  - IDLE → BUSY on `ex_mc_start` with `ex_mc_len` ≥ 2. Load `cnt` ← len−2.
  - IDLE, start with len = 1: the start cycle stalls, the FSM stays in IDLE, and `ex_mc_done` pulses in the next cycle.
  - IDLE, start with len = 0: no stall is asserted and `ex_mc_done` pulses in the next cycle.
  - BUSY with `cnt` ≠ 0: `cnt` decrements.
  - BUSY with `cnt` = 0: return to IDLE and register the `ex_mc_done` pulse.
  - `ex_mc_start` is ignored while in BUSY.
- **Performance counter:** `stall_cycles` increments when `stall[0]` = 1 and saturates at 0xFFFF_FFFF. `perf_clr` has priority over the increment.
- **Watchdog:** a 16-bit counter of consecutive stalled cycles. It clears on any cycle with `stall[0]` = 0. When it reaches `WDOG_LIMIT`, `stall_timeout` sets and stays set until `rst`. The counter holds at the limit.

## Timing
- `stall` is combinational from the requests and the registered FSM state. A pipeline register therefore holds or bubbles at the same edge the request is seen.
- **Timed operation:** for a start in cycle t with len N ≥ 1, the EX-level stall is asserted in cycles t through t+N−1. `ex_mc_done` = 1 in cycle t+N only. `ex_mc_busy` = 1 in cycles t+1 through t+N−1.
- An external higher-priority MEM request during BUSY overrides the pattern to `011111`. The counter keeps running.
- **Reset values:** `stall` = 0 while `rst` is high, regardless of the request inputs. State = IDLE, `cnt` = 0, `ex_mc_done` = 0, `ex_mc_busy` = 0, `stall_cycles` = 0, `stall_timeout` = 0, watchdog count = 0.
- **Reset mid-operation:** rst in BUSY aborts the operation with no done pulse. The first cycle after reset is IDLE.
- **Simultaneous `perf_clr` and stall:** the result is 0, not 1.

## Structure
- The shared defines header already used by the core supplies `RstEnable`, `Stop`/`NoStop` and `ZeroWord`.
- Add to it a `StallBus` width macro (5:0) and the four stall-pattern constants.
- One sub-module is natural: `mc_timer`, which holds the IDLE/BUSY FSM, `cnt` and the done pulse.
- Request priority, the counters and the watchdog stay in the top module.

## Test plan
- **Priority:** `stallreq_from_id` = 1 and `stallreq_from_mem` = 1 in the same cycle → `stall` = `011111`. With only ID → `000111`. With only IF → `000011`.
- **Timed operation, N = 5:** `ex_mc_start`, len = 5 at cycle 10 → `stall` = `001111` in cycles 10–14, `ex_mc_busy` in 11–14, `ex_mc_done` in cycle 15 only, `stall` = 0 at 15. A second start at cycle 12 is ignored.
- **Edge lengths:** len = 1 → stall only in the start cycle, done next cycle. len = 0 → no stall, done next cycle.
- **Counters:** 7 stalled cycles → `stall_cycles` = 7. `perf_clr` during a stall cycle → 0. Preload near 0xFFFFFFFF → the value saturates.
- **Watchdog:** `WDOG_LIMIT` = 8, IF request held for 8 cycles → `stall_timeout` sets and stays set after the request drops. A 7-cycle stall, a gap, then a 7-cycle stall → the flag never sets.
- **Reset mid-operation:** `rst` at cycle 3 of a len = 10 operation → `stall` = 0 during reset, no `ex_mc_done`, FSM in IDLE afterwards. A new start then behaves normally.
